// File: rtl/or_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// or_bus_arbiter_if
// Purpose : bundles the request/data/grant signals of the wired-OR bus
//           arbiter so requesters and the arbiter share one connection.
// Signals : req   - one request bit per requester
//           din   - requester i data at din[i*W +: W]
//           gnt   - registered one-hot (or zero) grant
//           valid - high while any grant is active
//           owner - index of the granted (or last granted) requester
//           Y     - OR of all data slices masked by their grant bits
// Modports: master - requester side (drives req/din, observes the bus)
//           slave  - arbiter side (observes req/din, drives grant and bus)
// ----------------------------------------------------------------------------
interface or_bus_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   localparam int OWNER_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req;
   logic [NREQ*W-1:0]  din;
   logic [NREQ-1:0]    gnt;
   logic               valid;
   logic [OWNER_W-1:0] owner;
   logic [W-1:0]       Y;

   modport master (
      output req,
      output din,
      input  gnt,
      input  valid,
      input  owner,
      input  Y
   );

   modport slave (
      input  req,
      input  din,
      output gnt,
      output valid,
      output owner,
      output Y
   );
endinterface

// File: rtl/or_bus_arbiter.sv
// ----------------------------------------------------------------------------
// or_bus_arbiter
// Purpose : round-robin arbiter sharing one W-bit wired-OR bus between NREQ
//           requesters. A registered one-hot grant masks every data slice, so
//           Y always carries only the current owner's data (zero when idle).
// Ports   : clk - rising-edge clock
//           rst - asynchronous, active-high reset
//           bus - or_bus_arbiter_if.slave (req, din in; gnt, valid, owner, Y out)
// Params  : NREQ (2..8), W, MAX_HOLD (>=2, only used with the timeout option);
//           NREQ and W must match the connected interface instance.
// Option  : define OR_ARB_TIMEOUT_EN to build the tenure counter that forces
//           an owner off the bus after MAX_HOLD granted cycles when another
//           requester is waiting. Without it the owner keeps the bus until it
//           drops its request.
// ----------------------------------------------------------------------------
module or_bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst,
   or_bus_arbiter_if.slave    bus
);
   localparam int OWNER_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state;
   logic [NREQ-1:0]    gnt_q;
   logic [OWNER_W-1:0] owner_q;
   logic [OWNER_W-1:0] ptr_q;

   logic               pick_vld;
   logic [OWNER_W-1:0] pick_idx;
   logic               force_rel;
   logic [W-1:0]       y_mux;

   // Round-robin successor of an index, wrapping at NREQ (NREQ need not be
   // a power of two).
   function automatic logic [OWNER_W-1:0] next_idx(input logic [OWNER_W-1:0] k);
      if (int'(k) >= NREQ - 1)
         return '0;
      else
         return k + 1'b1;
   endfunction

`ifdef OR_ARB_TIMEOUT_EN
   localparam int TEN_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [TEN_W-1:0] HOLD_LAST = TEN_W'((MAX_HOLD < 2) ? 1 : MAX_HOLD - 1);

   logic [TEN_W-1:0] tenure_q;

   // Tenure counts granted cycles after the first and sticks at HOLD_LAST.
   function automatic logic [TEN_W-1:0] sat_inc(input logic [TEN_W-1:0] t);
      if (t == HOLD_LAST)
         return t;
      else
         return t + 1'b1;
   endfunction

   // Only a waiting competitor can push the owner off; a lone owner keeps
   // the bus with a saturated tenure.
   assign force_rel = (tenure_q == HOLD_LAST) && (|(bus.req & ~gnt_q));
`else
   // MAX_HOLD has no effect in this build; values below 2 are unsupported.
   if (MAX_HOLD < 2) begin : g_max_hold_unsupported
   end

   assign force_rel = 1'b0;
`endif

   // First requester in search order ptr, ptr+1, ..., wrapping mod NREQ.
   // Scanning offsets downward lets the smallest offset win last.
   always_comb begin
      int idx;
      pick_vld = 1'b0;
      pick_idx = '0;
      idx      = 0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = int'(ptr_q) + off;
         if (idx >= NREQ)
            idx = idx - NREQ;
         if (bus.req[idx]) begin
            pick_vld = 1'b1;
            pick_idx = OWNER_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         ptr_q    <= '0;
`ifdef OR_ARB_TIMEOUT_EN
         tenure_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt_q    <= NREQ'(1) << pick_idx;
                  owner_q  <= pick_idx;
`ifdef OR_ARB_TIMEOUT_EN
                  tenure_q <= '0;
`endif
                  state    <= BUSY;
               end else begin
                  gnt_q <= '0;
               end
            end
            BUSY: begin
               // Releasing always passes through IDLE, which gives the
               // mandatory one-cycle bus turnaround before any new grant.
               if (!bus.req[owner_q] || force_rel) begin
                  gnt_q <= '0;
                  ptr_q <= next_idx(owner_q);
                  state <= IDLE;
               end else begin
`ifdef OR_ARB_TIMEOUT_EN
                  tenure_q <= sat_inc(tenure_q);
`endif
               end
            end
            default: begin
               gnt_q <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Wired-OR bus: every slice gated by its own grant bit.
   always_comb begin
      y_mux = '0;
      for (int i = 0; i < NREQ; i++)
         y_mux = y_mux | (bus.din[i*W +: W] & {W{gnt_q[i]}});
   end

   assign bus.gnt   = gnt_q;
   assign bus.valid = |gnt_q;
   assign bus.owner = owner_q;
   assign bus.Y     = y_mux;
endmodule

// File: tb/tb_or_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_or_bus_arbiter
// Directed bench for or_bus_arbiter (NREQ=4, W=8, MAX_HOLD=8): reset behaviour,
// single grant, round-robin contention, fairness, bus masking and tenure
// limit (timeout option) or unlimited hold (default build).
// ----------------------------------------------------------------------------
module tb_or_bus_arbiter;
   localparam int NREQ     = 4;
   localparam int W        = 8;
   localparam int MAX_HOLD = 8;

   logic clk;
   logic rst;

   int n_cmp;
   int n_err;

   or_bus_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   or_bus_arbiter #(
      .NREQ     (NREQ),
      .W        (W),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then sample at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int prev;
      int held;
      int k;

      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b1;
      bus.req = '0;
      bus.din = '0;
      @(negedge clk);
      @(negedge clk);

      check("rst_gnt",   32'(bus.gnt),   32'h0);
      check("rst_valid", 32'(bus.valid), 32'h0);
      check("rst_owner", 32'(bus.owner), 32'h0);
      check("rst_y",     32'(bus.Y),     32'h0);
      rst = 1'b0;

      // Async reset in the middle of a tenure
      bus.din = {8'h00, 8'h00, 8'h00, 8'h3C};
      bus.req = 4'b0001;
      tick();
      check("ar_gnt",   32'(bus.gnt),   32'h1);
      check("ar_valid", 32'(bus.valid), 32'h1);
      check("ar_y",     32'(bus.Y),     32'h3C);
      #1 rst = 1'b1;
      #1;
      check("ar_clr_gnt",   32'(bus.gnt),   32'h0);
      check("ar_clr_valid", 32'(bus.valid), 32'h0);
      check("ar_clr_y",     32'(bus.Y),     32'h0);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ar_regrant", 32'(bus.gnt),   32'h1);
      check("ar_owner",   32'(bus.owner), 32'h0);
      bus.req = '0;
      tick();
      check("ar_release", 32'(bus.gnt), 32'h0);
      tick();

      // Single request, other slices all ones
      bus.din = {8'hFF, 8'hA5, 8'hFF, 8'hFF};
      bus.req = 4'b0100;
      tick();
      check("single_gnt",   32'(bus.gnt),   32'h4);
      check("single_owner", 32'(bus.owner), 32'h2);
      check("single_valid", 32'(bus.valid), 32'h1);
      check("single_y",     32'(bus.Y),     32'hA5);
      bus.req = '0;
      tick();
      check("single_idle_y",     32'(bus.Y),     32'h0);
      check("single_idle_owner", 32'(bus.owner), 32'h2);
      tick();

      // Full contention after reset: order 0,1,2,3 with one idle cycle each
      pulse_reset();
      bus.din = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.req = 4'b1111;
      tick();
      for (int i = 0; i < NREQ; i++) begin
         check($sformatf("rr_gnt%0d", i),   32'(bus.gnt),   32'(1 << i));
         check($sformatf("rr_owner%0d", i), 32'(bus.owner), 32'(i));
         check($sformatf("rr_y%0d", i),     32'(bus.Y),     32'(8'h11 * (i + 1)));
         tick();
         tick();
         check($sformatf("rr_hold%0d", i), 32'(bus.gnt), 32'(1 << i));
         bus.req[i] = 1'b0;
         tick();
         check($sformatf("rr_gap%0d", i), 32'(bus.gnt), 32'h0);
         tick();
      end
      check("rr_end_idle", 32'(bus.gnt), 32'h0);

      // Fairness: 0 and 2 re-request immediately after each release
      bus.req = 4'b0101;
      tick();
      prev = -1;
      for (int n = 0; n < 4; n++) begin
         k = (n % 2 == 0) ? 0 : 2;
         check($sformatf("fair_gnt%0d", n),   32'(bus.gnt),   32'(1 << k));
         check($sformatf("fair_alt%0d", n),   32'(int'(bus.owner) != prev), 32'h1);
         prev = int'(bus.owner);
         bus.req[k] = 1'b0;
         tick();
         check($sformatf("fair_gap%0d", n), 32'(bus.gnt), 32'h0);
         bus.req[k] = 1'b1;
         tick();
      end
      bus.req = '0;
      tick();
      tick();

      // Masking: owner 1 with 0F while 3 waits with F0
      bus.din = {8'hF0, 8'hFF, 8'h0F, 8'hFF};
      bus.req = 4'b0010;
      tick();
      check("mask_gnt1", 32'(bus.gnt), 32'h2);
      bus.req = 4'b1010;
      tick();
      check("mask_hold", 32'(bus.gnt), 32'h2);
      check("mask_y1",   32'(bus.Y),   32'h0F);
      bus.req[1] = 1'b0;
      tick();
      check("mask_gap_y", 32'(bus.Y), 32'h0);
      tick();
      check("mask_gnt3",  32'(bus.gnt),   32'h8);
      check("mask_own3",  32'(bus.owner), 32'h3);
      check("mask_y3",    32'(bus.Y),     32'hF0);
      bus.din[31:24] = 8'h5A;
      #1;
      check("mask_y_comb", 32'(bus.Y), 32'h5A);
      bus.req = '0;
      tick();
      tick();

      // Tenure limit with a waiting competitor
      pulse_reset();
      bus.din = {8'h00, 8'h00, 8'h77, 8'h66};
      bus.req = 4'b0001;
      tick();
      check("to_gnt0", 32'(bus.gnt), 32'h1);
      bus.req = 4'b0011;
`ifdef OR_ARB_TIMEOUT_EN
      for (int c = 1; c < MAX_HOLD; c++) begin
         tick();
         check($sformatf("to_hold%0d", c), 32'(bus.gnt), 32'h1);
      end
      tick();
      check("to_forced_gap", 32'(bus.gnt), 32'h0);
      tick();
      check("to_gnt1",  32'(bus.gnt),   32'h2);
      check("to_own1",  32'(bus.owner), 32'h1);
      check("to_y1",    32'(bus.Y),     32'h77);
`else
      held = 0;
      for (int c = 0; c < 55; c++) begin
         tick();
         if (bus.gnt == 4'b0001)
            held++;
      end
      check("nto_held_cycles", 32'(held), 32'd55);
      check("nto_owner",       32'(bus.owner), 32'h0);
      check("nto_y",           32'(bus.Y),     32'h66);
`endif
      bus.req = '0;
      tick();
      check("final_idle", 32'(bus.gnt), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/or_bus_arbiter.md
# or_bus_arbiter

Round-robin arbiter that shares one W-bit wired-OR output bus between NREQ requesters. Each requester drives its data slice. The bus output is the OR of all slices, each masked by its grant bit. The registered one-hot grant guarantees that only one slice reaches the bus, so Y always equals the current owner's data. The block sits in front of the team's OR-gate datapath and sequences access to it.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 8: data width per requester
- MAX_HOLD, 8: maximum grant tenure in cycles; used only when OR_ARB_TIMEOUT_EN is defined (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  request; req[i] stays high for the whole transfer
- din  input  NREQ*W  requester i data at din[i*W +: W]
- gnt  output  NREQ  registered grant, one-hot or zero
- valid  output  1  equals |gnt
- owner  output  $clog2(NREQ)  index of the granted requester; holds the last owner when idle
- Y  output  W  OR over i of (din[i] masked by gnt[i]); combinational from the registered gnt and from din

## Operation
- Reset values: state=IDLE, gnt=0, valid=0, owner=0, Y=0, ptr=0, tenure=0.
- ptr is the highest-priority index for the next arbitration.
- Search order: ptr, ptr+1, …, NREQ-1, 0, …, ptr-1, wrapping mod NREQ.
- FSM states:
  - IDLE:
    - If req≠0: grant the first requester with req high in search order.
    - gnt[k]←1, owner←k, tenure←0, next state BUSY.
    - If req=0: stay in IDLE with gnt=0.
  - BUSY (owner k):
    - If req[k]=1: hold gnt; tenure increments and saturates at MAX_HOLD-1.
    - If req[k]=0: gnt←0, ptr←(k+1) mod NREQ, next state IDLE.
- The owner's release and a new grant never occur on the same edge. This one-cycle bus turnaround is mandatory.
- Requests from non-owners during BUSY are ignored until the owner releases. Nothing is queued beyond the live req level.
- din of non-granted requesters never affects Y, so Y=0 whenever gnt=0.
- A requester that drops req while not granted loses nothing; there is no pending state.
- Reset mid-BUSY:
  - gnt, valid and Y clear immediately, without waiting for an edge.
  - ptr returns to 0.
  - The first arbitration after reset release favours requester 0.

## Timing
- Request to grant latency when idle: req sampled at edge t, gnt high after edge t. Grant is one cycle after the request is presented.
- Release: req[k] low at edge t, gnt low after edge t. The earliest next grant is after edge t+1.
- Minimum gap between consecutive tenures: 1 idle cycle.
- Y settles combinationally within the same cycle as a gnt or din change. No output register is on Y.
- A simultaneous request from all requesters in IDLE resolves by ptr alone. There is no fixed priority beyond reset.

## Configuration
- OR_ARB_TIMEOUT_EN defined: forced release.
  - In BUSY, if tenure=MAX_HOLD-1 and any other req[j]=1 (j≠k) at an edge, force the release.
  - Forced release: gnt←0, ptr←(k+1) mod NREQ, next state IDLE. This matches a normal release.
  - If no other requester is waiting, the owner keeps the grant and tenure stays saturated.
  - A forced-out requester keeping req high re-competes by round robin.
- OR_ARB_TIMEOUT_EN undefined:
  - The tenure counter and the MAX_HOLD logic are not built.
  - The owner holds the grant until it drops req.

## Test plan
- Async reset: hold req=4'b0001 until gnt=4'b0001, then pulse rst mid-cycle. gnt=0, valid=0 and Y=0 must clear before the next edge. After release, requester 0 is re-granted one cycle later.
- Single request: req=4'b0100, din[2]=8'hA5, all other din=8'hFF. One cycle later: gnt=4'b0100, owner=2, valid=1, Y=8'hA5.
- Full contention after reset: req=4'b1111. Each owner drops req 3 cycles after it is granted. Required grant order 0,1,2,3, with exactly one gnt=0 cycle between tenures.
- Fairness: req0 and req2 re-assert immediately after each release. Grants must alternate 0,2,0,2 and requester 0 must never win twice in a row.
- Masking: requester 1 is granted with din[1]=8'h0F while requester 3 waits with din[3]=8'hF0. Y must be 8'h0F, not 8'hFF. After the handover to requester 3, Y=8'hF0.
- Timeout, OR_ARB_TIMEOUT_EN with MAX_HOLD=8: req0 is held permanently and req1 is asserted at the grant edge. gnt[0] drops after 8 granted cycles, followed by one idle cycle, then gnt[1]=1. Without the macro, gnt[0] must remain high for more than 50 cycles.
